// File: rtl/ahb_gpio_arbiter.sv
// Two-master AHB-Lite arbiter sharing one slave port. A losing or stalled address
// phase is parked in a per-master holding register and re-issued when the slave is free.
module ahb_gpio_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [2:0]            m0_hsize,
  input  logic                  m0_hmastlock,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [2:0]            m1_hsize,
  input  logic                  m1_hmastlock,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic                  s_hsel,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [1:0]            s_htrans,
  output logic                  s_hwrite,
  output logic [2:0]            s_hsize,
  output logic                  s_hmastlock,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  output logic                  s_hmaster,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [1:0]            in_trans [2];
  logic [2:0]            in_size [2];
  logic [DATA_WIDTH-1:0] in_wdata [2];
  logic [1:0]            in_write, in_lock;

  logic [ADDR_WIDTH-1:0] pend_addr [2];
  logic [1:0]            pend_trans [2];
  logic [2:0]            pend_size [2];
  logic [1:0]            pend_v, pend_write, pend_lock;

  logic [1:0] hready_o, own, live, req, elig, gnt_vec;
  logic       gnt_any, g;
  logic       dvalid, d_owner, lock_valid, lock_owner, rr_ptr, addr_owner;
  logic       lock_idle;
  logic [ADDR_WIDTH-1:0] haddr_q, iss_addr;
  logic [1:0]            iss_trans;
  logic [2:0]            iss_size;
  logic                  iss_write, iss_lock;

  assign in_addr[0]  = m0_haddr;   assign in_addr[1]  = m1_haddr;
  assign in_trans[0] = m0_htrans;  assign in_trans[1] = m1_htrans;
  assign in_size[0]  = m0_hsize;   assign in_size[1]  = m1_hsize;
  assign in_wdata[0] = m0_hwdata;  assign in_wdata[1] = m1_hwdata;
  assign in_write    = {m1_hwrite, m0_hwrite};
  assign in_lock     = {m1_hmastlock, m0_hmastlock};

  // A master owning the data phase sees the slave's hready; otherwise it is
  // stalled only while its address phase sits in the holding register.
  for (genvar m = 0; m < 2; m++) begin : g_master
    assign own[m]      = dvalid & (d_owner == 1'(m));
    assign hready_o[m] = own[m] ? s_hready : ~pend_v[m];
    assign live[m]     = in_trans[m][1] & hready_o[m];
    assign req[m]      = pend_v[m] | live[m];
    assign elig[m]     = req[m] & (~lock_valid | (lock_owner == 1'(m)));
    assign gnt_vec[m]  = gnt_any & (g == 1'(m));
  end

  always_comb begin
    gnt_any = s_hready & (|elig);
    if (ROUND_ROBIN != 0) g = elig[rr_ptr] ? rr_ptr : ~rr_ptr;
    else                  g = ~elig[0];
    iss_addr  = pend_v[g] ? pend_addr[g]  : in_addr[g];
    iss_trans = pend_v[g] ? pend_trans[g] : in_trans[g];
    iss_write = pend_v[g] ? pend_write[g] : in_write[g];
    iss_size  = pend_v[g] ? pend_size[g]  : in_size[g];
    iss_lock  = pend_v[g] ? pend_lock[g]  : in_lock[g];
  end

  // Lock owner went idle without keeping hmastlock asserted.
  assign lock_idle = lock_valid & s_hready & ~pend_v[lock_owner] &
                     ~in_trans[lock_owner][1] & ~in_lock[lock_owner];

  assign s_hsel      = gnt_any;
  assign s_haddr     = gnt_any ? iss_addr : haddr_q;
  assign s_htrans    = gnt_any ? iss_trans : 2'b00;
  assign s_hwrite    = gnt_any & iss_write;
  assign s_hsize     = gnt_any ? iss_size : 3'b000;
  assign s_hmastlock = gnt_any & iss_lock;
  assign s_hmaster   = gnt_any ? g : addr_owner;
  assign s_hwdata    = dvalid ? in_wdata[d_owner] : '0;

  assign m0_hready = hready_o[0];
  assign m1_hready = hready_o[1];
  assign m0_hrdata = own[0] ? s_hrdata : '0;
  assign m1_hrdata = own[1] ? s_hrdata : '0;
  assign m0_hresp  = own[0] & s_hresp;
  assign m1_hresp  = own[1] & s_hresp;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int m = 0; m < 2; m++) begin
        pend_addr[m]  <= '0;
        pend_trans[m] <= 2'b00;
        pend_size[m]  <= 3'b000;
      end
      pend_v     <= 2'b00;
      pend_write <= 2'b00;
      pend_lock  <= 2'b00;
      haddr_q    <= '0;
      addr_owner <= 1'b0;
      rr_ptr     <= 1'b0;
      dvalid     <= 1'b0;
      d_owner    <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (live[m] && !gnt_vec[m]) begin
          pend_v[m]     <= 1'b1;
          pend_addr[m]  <= in_addr[m];
          pend_trans[m] <= in_trans[m];
          pend_write[m] <= in_write[m];
          pend_size[m]  <= in_size[m];
          pend_lock[m]  <= in_lock[m];
        end else if (gnt_vec[m]) begin
          pend_v[m] <= 1'b0;
        end
      end
      if (gnt_any) begin
        haddr_q    <= iss_addr;
        addr_owner <= g;
        if (ROUND_ROBIN != 0) rr_ptr <= ~g;
        if (iss_lock) begin
          lock_valid <= 1'b1;
          lock_owner <= g;
        end else if (lock_valid && (g == lock_owner)) begin
          lock_valid <= 1'b0;
        end
      end else if (lock_idle) begin
        lock_valid <= 1'b0;
      end
      if (s_hready) begin
        dvalid  <= gnt_any;
        d_owner <= g;
      end
    end
  end

endmodule

// File: doc/ahb_gpio_arbiter.md
Name: ahb_gpio_arbiter

Overview:
Two-master AHB-Lite arbiter that shares one slave port, typically the AHB GPIO block, between the CPU data port (M0) and a secondary master such as DMA or debug (M1). A master that loses arbitration, or that arrives while the slave is stalled, has its address phase captured in a per-master holding register. Its data phase is then stretched with hready low until the held transfer completes on the slave. Adds no latency when the bus is free; honours hmastlock.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width
ROUND_ROBIN, 0, 0 = fixed priority (M0 highest); 1 = alternate after each grant

Ports:
HCLK  input  1  clock, all state on rising edge
HRESETn  input  1  reset; one clock; reset is asynchronous and active-low
m0_haddr  input  ADDR_WIDTH  M0 address
m0_htrans  input  2  M0 transfer type (bit1 = NONSEQ/SEQ)
m0_hwrite  input  1  M0 write
m0_hsize  input  3  M0 size
m0_hmastlock  input  1  M0 locked sequence
m0_hwdata  input  DATA_WIDTH  M0 write data (data phase)
m0_hrdata  output  DATA_WIDTH  M0 read data
m0_hready  output  1  M0 ready
m0_hresp  output  1  M0 response (1 = ERROR)
m1_haddr..m1_hresp  as m0_*  -  identical port set for M1
s_hsel  output  1  slave select, high when a transfer is issued
s_haddr  output  ADDR_WIDTH  slave address
s_htrans  output  2  slave transfer type
s_hwrite  output  1  slave write
s_hsize  output  3  slave size
s_hmastlock  output  1  slave lock
s_hwdata  output  DATA_WIDTH  write data muxed from the data-phase owner
s_hmaster  output  1  current address-phase owner
s_hrdata  input  DATA_WIDTH  slave read data
s_hready  input  1  slave ready
s_hresp  input  1  slave response

Behaviour:
- State:
  - pend_m: valid bit plus captured addr/trans/write/size/lock, one per master.
  - addr_owner.
  - dvalid/d_owner: the data-phase owner.
  - lock_valid/lock_owner.
  - rr_ptr: the master to favour next.
- Reset (async): pend, dvalid, lock_valid cleared; rr_ptr = M0.
  - Outputs at reset: m*_hready = 1, m*_hresp = 0, m*_hrdata = 0, s_hsel = 0, s_htrans = IDLE, s_haddr = 0, s_hmaster = 0.
  - Reset mid-transfer drops all pending transfers.
- Live request: live_m = m_htrans[1] & m_hready.
- Request: req_m = pend_m | live_m. The two terms are mutually exclusive, because hready_m is low while pend_m is set.
- Arbitration happens only when s_hready = 1.
  - If lock_valid, only lock_owner is eligible.
  - Otherwise, with ROUND_ROBIN = 0, M0 wins over M1.
  - With ROUND_ROBIN = 1, the rr_ptr master wins, and rr_ptr flips to the other master after any grant.
- Granted master drives the slave combinationally, from its pend_m register if set, else from its live inputs. s_hsel = 1.
- No grant: s_hsel = 0, s_htrans = IDLE, s_haddr holds its last value.
- A live request that is not granted this cycle, because it lost or because s_hready = 0, is written to pend_m at the clock edge.
- pend_m clears on the edge where it is granted.
- Data-phase tracking: on an edge with s_hready = 1, dvalid <= grant issued and d_owner <= granted master.
- m_hready:
  - If dvalid & d_owner == m: s_hready.
  - Otherwise: ~pend_m.
- m_hrdata and m_hresp follow s_hrdata and s_hresp when dvalid & d_owner == m; otherwise both are 0.
- s_hwdata = hwdata of d_owner; 0 when dvalid = 0.
- Lock:
  - A granted transfer with hmastlock = 1 sets lock_valid and lock_owner.
  - A granted transfer, or IDLE, from lock_owner with hmastlock = 0 clears it.
  - While locked, the other master's requests remain pending.
- ERROR: the slave's two-cycle response passes through to the owner unchanged. A pending transfer of the erroring master is still issued; it is not cancelled.
- Simultaneous data-phase completion and loss of a new address for the same master: hready = 1 this cycle (completes the old transfer), then 0 from the next cycle.

Test Plan:
1. M0 alone reads 0x0000_0004, zero-wait slave returning 0x0000_00A5 -> s_haddr = 0x4 in the same cycle, m0_hready stays 1, m0_hrdata = 0xA5 next cycle, s_hmaster = 0.
2. ROUND_ROBIN = 0; M0 write 0x4/0x0000_ABCD and M1 read 0x8 in the same cycle ->
   - Cycle 0: M0 issued.
   - Cycle 1: M1 issued from pend; s_hwdata = 0xABCD; m1_hready = 0.
   - Cycle 2: m1_hready = 1 with the read data.
3. ROUND_ROBIN = 1; both masters stream 4 NONSEQ each -> s_hmaster sequence 0,1,0,1,0,1,0,1; no transfer lost or duplicated.
4. M1 locked writes to 0x4, 0x8, 0xC, the last with hmastlock = 0, while M0 requests -> M0 held (m0_hready = 0) until after the 0xC address phase, then issued.
5. Slave holds s_hready = 0 for 2 cycles in an M0 data phase while M1 requests 0x8 -> no s_haddr change, M1 issued on the first s_hready = 1 cycle. Then assert HRESETn = 0 with M0 pending -> reset values immediately, no further issue.
6. Slave ERROR for an M0 access to 0x10 -> m0_hresp = 1 for 2 cycles with m0_hready 0 then 1; m1_hresp stays 0.
